// File: rtl/dmem_byte_arbiter.sv
// Round-robin arbiter that serialises two 32-bit word requesters onto a
// byte-wide, single-port data memory as four little-endian byte beats.
module dmem_byte_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [31:0]       wdata0_i,
    output logic [31:0]       rdata0_o,
    output logic              ack0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [31:0]       wdata1_i,
    output logic [31:0]       rdata1_o,
    output logic              ack1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_rdata_i
);
    // state | meaning
    // IDLE  | no transfer; samples requests and grants round-robin
    // BEAT  | one byte strobe per cycle, beat k = 0..3
    // DONE  | last read byte on mem_rdata_i; ack pulse to granted port
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t            state;
    logic [1:0]        beat;
    logic              last_grant;
    logic              cur_port;
    logic              cur_we;
    logic [ADDR_W-3:0] cur_base;
    logic [31:0]       cur_wdata;
    logic [23:0]       rbuf;
    logic [31:0]       res0;
    logic [31:0]       res1;

    logic              any_req;
    logic              gnt_port;
    logic              sel_we;
    logic [ADDR_W-3:0] sel_base;
    logic [31:0]       sel_wdata;
    logic [1:0]        beat_nx;
    logic [31:0]       rd_word;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{addr0_i[1:0], addr1_i[1:0]};

    always_comb begin
        any_req  = req0_i | req1_i;
        gnt_port = 1'b0;
        if (req0_i && req1_i) begin
            gnt_port = ~last_grant;
        end else if (req1_i) begin
            gnt_port = 1'b1;
        end
        sel_we    = gnt_port ? we1_i : we0_i;
        sel_base  = gnt_port ? addr1_i[ADDR_W-1:2] : addr0_i[ADDR_W-1:2];
        sel_wdata = gnt_port ? wdata1_i : wdata0_i;
        beat_nx   = beat + 2'd1;
        rd_word   = {mem_rdata_i, rbuf};
    end

    // Byte 3 is only on mem_rdata_i during DONE, so it is forwarded while ack is high.
    always_comb begin
        rdata0_o = res0;
        rdata1_o = res1;
        if (state == DONE && !cur_we) begin
            if (cur_port) begin
                rdata1_o = rd_word;
            end else begin
                rdata0_o = rd_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            beat        <= 2'd0;
            last_grant  <= 1'b1;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            cur_base    <= '0;
            cur_wdata   <= '0;
            rbuf        <= '0;
            res0        <= '0;
            res1        <= '0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            mem_re_o    <= 1'b0;
        end else begin
            ack0_o   <= 1'b0;
            ack1_o   <= 1'b0;
            mem_we_o <= 1'b0;
            mem_re_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= BEAT;
                        beat        <= 2'd0;
                        cur_port    <= gnt_port;
                        last_grant  <= gnt_port;
                        cur_we      <= sel_we;
                        cur_base    <= sel_base;
                        cur_wdata   <= sel_wdata;
                        mem_addr_o  <= {sel_base, 2'b00};
                        mem_we_o    <= sel_we;
                        mem_re_o    <= ~sel_we;
                        mem_wdata_o <= sel_we ? sel_wdata[7:0] : 8'h00;
                    end
                end
                BEAT: begin
                    // Read data lags its strobe by one cycle, so beat k captures byte k-1.
                    if (!cur_we) begin
                        case (beat)
                            2'd1:    rbuf[7:0]   <= mem_rdata_i;
                            2'd2:    rbuf[15:8]  <= mem_rdata_i;
                            2'd3:    rbuf[23:16] <= mem_rdata_i;
                            default: ;
                        endcase
                    end
                    if (beat == 2'd3) begin
                        state  <= DONE;
                        ack0_o <= ~cur_port;
                        ack1_o <= cur_port;
                    end else begin
                        beat        <= beat_nx;
                        mem_addr_o  <= {cur_base, beat_nx};
                        mem_we_o    <= cur_we;
                        mem_re_o    <= ~cur_we;
                        mem_wdata_o <= cur_we ? cur_wdata[{beat_nx, 3'b000} +: 8] : 8'h00;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!cur_we) begin
                        if (cur_port) begin
                            res1 <= rd_word;
                        end else begin
                            res0 <= rd_word;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Scoreboard bench for dmem_byte_arbiter: the driver predicts each word
// transaction from a shadow memory, a negedge monitor checks beats and acks.
module tb_dmem_byte_arbiter;
    localparam int ADDR_W = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_i, we0_i, req1_i, we1_i;
    logic [ADDR_W-1:0] addr0_i, addr1_i;
    logic [31:0]       wdata0_i, wdata1_i, rdata0_o, rdata1_o;
    logic              ack0_o, ack1_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_we_o, mem_re_o;
    logic [7:0]        mem_rdata_i;

    dmem_byte_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
        .rdata0_o(rdata0_o), .ack0_o(ack0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .rdata1_o(rdata1_o), .ack1_o(ack1_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Registered byte memory
    logic [7:0] mem [32];
    logic [7:0] init_val [32];
    logic       mem_load;
    always @(posedge clk_i) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val[i];
        end else begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [4:0]  base;
        logic [31:0] wdata;
        logic [31:0] rexp;
        int          start;
    } txn_t;
    txn_t exp_q[$];

    // Monitor
    int          beat_n = 0;
    int          last_beat = 0;
    logic [31:0] hold0 = '0;
    logic [31:0] hold1 = '0;
    txn_t        mt;
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            exp_q.delete();
            beat_n = 0;
            hold0  = '0;
            hold1  = '0;
            chk("reset_strobes", 32'({mem_we_o, mem_re_o}), 32'd0);
            chk("reset_acks", 32'({ack0_o, ack1_o}), 32'd0);
        end else begin
            chk("strobe_exclusive", 32'(mem_we_o & mem_re_o), 32'd0);
            if (mem_we_o || mem_re_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else if (beat_n > 3) begin
                    chk("extra_beat", 32'(beat_n), 32'd3);
                end else begin
                    mt = exp_q[0];
                    chk("beat_cycle", 32'(cyc), 32'(beat_n == 0 ? mt.start : last_beat + 1));
                    chk("beat_we", 32'(mem_we_o), 32'(mt.we));
                    chk("beat_addr", 32'(mem_addr_o), 32'({mt.base[4:2], 2'(beat_n)}));
                    if (mt.we) chk("beat_wdata", 32'(mem_wdata_o), 32'(mt.wdata[8*beat_n +: 8]));
                    beat_n++;
                    last_beat = cyc;
                end
            end
            if (ack0_o || ack1_o) begin
                chk("ack_onehot", 32'(ack0_o & ack1_o), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mt = exp_q.pop_front();
                    chk("ack_port", 32'(ack1_o), 32'(mt.port));
                    chk("ack_beats", 32'(beat_n), 32'd4);
                    chk("ack_latency", 32'(cyc), 32'(last_beat + 1));
                    if (!mt.we) begin
                        if (mt.port) hold1 = mt.rexp;
                        else         hold0 = mt.rexp;
                    end
                    beat_n = 0;
                end
            end
        end
        chk("rdata0", rdata0_o, hold0);
        chk("rdata1", rdata1_o, hold1);
    end

    // Driver and reference model
    logic [7:0]  shadow [32];
    bit          pv [2];
    bit          pwe [2];
    logic [4:0]  pad [2];
    logic [31:0] pwd [2];
    bit          last_g   = 1'b1;
    int          last_ack = -10;

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drive_port(input int p);
        if (p == 0) begin
            req0_i = pv[0]; we0_i = pwe[0]; addr0_i = pad[0]; wdata0_i = pwd[0];
        end else begin
            req1_i = pv[1]; we1_i = pwe[1]; addr1_i = pad[1]; wdata1_i = pwd[1];
        end
    endtask

    task automatic set_op(input int p, input bit we, input logic [4:0] a, input logic [31:0] d);
        pv[p] = 1'b1; pwe[p] = we; pad[p] = a; pwd[p] = d;
    endtask

    task automatic fill(input int p);
        set_op(p, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    endtask

    function automatic txn_t predict(input bit w, input int start);
        txn_t t;
        int   b;
        t.port  = w;
        t.we    = pwe[w];
        t.base  = {pad[w][4:2], 2'b00};
        t.wdata = pwd[w];
        t.start = start;
        b = int'(t.base);
        t.rexp = {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
        return t;
    endfunction

    task automatic serve_one(input bit perturb, output bit w);
        txn_t t;
        int   start;
        int   b;
        bit   got;
        drive_port(0);
        drive_port(1);
        w      = (pv[0] && pv[1]) ? ~last_g : pv[1];
        last_g = w;
        start  = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
        t = predict(w, start);
        if (t.we) begin
            b = int'(t.base);
            for (int i = 0; i < 4; i++) shadow[b+i] = t.wdata[8*i +: 8];
        end
        exp_q.push_back(t);
        for (int i = 0; i < 20 && cyc < start; i++) step();
        if (perturb) begin
            if (w) begin
                we1_i = 1'($urandom); addr1_i = 5'($urandom); wdata1_i = $urandom;
                if ($urandom_range(0, 1) == 1) req1_i = 1'b0;
            end else begin
                we0_i = 1'($urandom); addr0_i = 5'($urandom); wdata0_i = $urandom;
                if ($urandom_range(0, 1) == 1) req0_i = 1'b0;
            end
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = w ? ack1_o : ack0_o;
        end
        chk("ack_wait", 32'(got), 32'd1);
        last_ack = cyc;
        pv[w] = 1'b0;
        drive_port(int'(w));
    endtask

    initial begin
        bit   w;
        txn_t t;
        int   start;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   w;
        txn_t t;
        int   start;
        logic [31:0] d;

        rst_i = 1'b1;
        mem_load = 1'b1;
        for (int i = 0; i < 32; i++) begin
            init_val[i] = 8'($urandom);
            shadow[i]   = init_val[i];
        end
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0;
            drive_port(p);
        end
        repeat (3) step();
        chk("rst_ack0", 32'(ack0_o), 32'd0);
        chk("rst_ack1", 32'(ack1_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_re", 32'(mem_re_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
        chk("rst_rdata0", rdata0_o, 32'd0);
        chk("rst_rdata1", rdata1_o, 32'd0);
        rst_i = 1'b0;
        mem_load = 1'b0;

        // Port 0 word write, then port 1 read with unaligned address
        set_op(0, 1'b1, 5'h04, 32'hAABBCCDD);
        serve_one(1'b0, w);
        step();
        chk("wr_mem4", 32'(mem[4]), 32'hDD);
        chk("wr_mem5", 32'(mem[5]), 32'hCC);
        chk("wr_mem6", 32'(mem[6]), 32'hBB);
        chk("wr_mem7", 32'(mem[7]), 32'hAA);
        set_op(1, 1'b0, 5'h05, 32'h0);
        serve_one(1'b0, w);
        chk("rd_word_p1", rdata1_o, 32'hAABBCCDD);

        // Port 1 alone, back to back
        for (int i = 0; i < 3; i++) begin
            fill(1);
            serve_one(1'b0, w);
        end

        // Top word
        set_op(0, 1'b1, 5'h1C, 32'h12345678);
        serve_one(1'b0, w);
        set_op(1, 1'b0, 5'h1F, 32'h0);
        serve_one(1'b0, w);
        chk("top_word", rdata1_o, 32'h12345678);

        // Reset while a port 0 write is mid-transfer
        d = $urandom;
        set_op(0, 1'b1, 5'h08, d);
        drive_port(0);
        drive_port(1);
        start = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
        t = predict(1'b0, start);
        exp_q.push_back(t);
        for (int i = 0; i < 20 && cyc < start + 1; i++) step();
        rst_i  = 1'b1;
        pv[0]  = 1'b0;
        drive_port(0);
        step();
        chk("midrst_we", 32'(mem_we_o), 32'd0);
        chk("midrst_ack0", 32'(ack0_o), 32'd0);
        rst_i    = 1'b0;
        last_g   = 1'b1;
        last_ack = -10;
        shadow[8] = d[7:0];
        shadow[9] = d[15:8];
        for (int i = 8; i < 12; i++) chk("midrst_mem", 32'(mem[i]), 32'(shadow[i]));

        // Both requesting from reset: alternating grants starting with port 0
        set_op(0, 1'b0, 5'h08, 32'h0);
        fill(1);
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b0, w);
            fill(int'(w));
        end
        serve_one(1'b0, w);
        serve_one(1'b0, w);

        // Randomised traffic with post-grant input changes
        for (int r = 0; r < 60; r++) begin
            if (!pv[0] && !pv[1] && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 60) fill(p);
            end
            if (!pv[0] && !pv[1]) fill(int'($urandom_range(0, 1)));
            serve_one(1'b1, w);
        end
        if (pv[0] || pv[1]) serve_one(1'b0, w);

        repeat (4) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
